// File: rtl/arb_pkg.sv
// Shared encodings and defaults for the fetch / load-store memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of load/store grants made while fetch was waiting; sat forces a fetch grant.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sat = (cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and load/store (LS), one transaction at a time.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT consecutive LS grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_t state, next_state;
  logic       grant_if, grant_ls;
  logic       force_if;
  logic       done_if, done_ls;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant_ls & if_req),
    .clr (grant_if),
    .sat (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // LS has strict priority unless the starvation guard says a waiting fetch must go first.
  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req && !(if_req && force_if)) begin
          grant_ls   = 1'b1;
          next_state = GNT_LS;
        end else if (if_req) begin
          grant_if   = 1'b1;
          next_state = GNT_IF;
        end
      end
      GNT_IF, GNT_LS: begin
        if (mem_ready) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign done_if = (state == GNT_IF) && mem_ready;
  assign done_ls = (state == GNT_LS) && mem_ready;
  assign mem_req = (state == GNT_IF) || (state == GNT_LS);
  assign busy    = (state != IDLE);

  // Transaction fields latch at grant and hold until memory completes; valids mark the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
    end else begin
      if_valid <= done_if;
      ls_valid <= done_ls;
      if (grant_ls) begin
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
      end else if (grant_if) begin
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (done_if) begin
        if_rdata <= mem_rdata;
        mem_we   <= 1'b0;
      end
      if (done_ls) begin
        if (!mem_we) ls_rdata <= mem_rdata;
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store/load, contention, spurious ready, latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        ls_req;
  logic        ls_we;
  logic [7:0]  ls_addr;
  logic [15:0] ls_wdata;
  logic [15:0] ls_rdata;
  logic        ls_valid;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_if_rd;
  logic [15:0] exp_ls_rd;

  mem_port_arbiter #(.AW(8), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_rdata  (ls_rdata),
    .ls_valid  (ls_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_req"},  mem_req,  0);
    chk({tag, "_mem_we"},   mem_we,   0);
    chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_ls_valid"}, ls_valid, 0);
    chk({tag, "_busy"},     busy,     0);
  endtask

  // One full transaction with d wait cycles in GNT before mem_ready; spur pulses ready during RESP.
  task automatic xact(input string tag, input bit is_ls, input bit we, input logic [7:0] addr,
                      input logic [15:0] wdata, input logic [15:0] rdata, input int d,
                      input bit spur);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    tick();
    chk({tag, "_gnt_mem_req"},  mem_req,  1);
    chk({tag, "_gnt_mem_addr"}, mem_addr, addr);
    chk({tag, "_gnt_mem_we"},   mem_we,   is_ls & we);
    if (is_ls && we) chk({tag, "_gnt_mem_wdata"}, mem_wdata, wdata);
    for (int i = 0; i < d; i++) begin
      tick();
      chk({tag, "_wait_mem_req"},  mem_req,  1);
      chk({tag, "_wait_mem_addr"}, mem_addr, addr);
      chk({tag, "_wait_valid"},    {if_valid, ls_valid}, 0);
    end
    mem_rdata = rdata;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    if (!is_ls) exp_if_rd = rdata;
    else if (!we) exp_ls_rd = rdata;
    chk({tag, "_resp_mem_req"},  mem_req,  0);
    chk({tag, "_resp_if_valid"}, if_valid, !is_ls);
    chk({tag, "_resp_ls_valid"}, ls_valid, is_ls);
    chk({tag, "_resp_if_rdata"}, if_rdata, exp_if_rd);
    chk({tag, "_resp_ls_rdata"}, ls_rdata, exp_ls_rd);
    if (spur) begin
      mem_rdata = 16'hDEAD;
      mem_ready = 1'b1;
    end
    tick();
    mem_ready = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    chk_idle_outputs({tag, "_after"});
    chk({tag, "_after_if_rdata"}, if_rdata, exp_if_rd);
    chk({tag, "_after_ls_rdata"}, ls_rdata, exp_ls_rd);
  endtask

  function automatic bit exp_ls_grant(input int i);
`ifdef ARB_STARVE_GUARD_EN
    return (i != 4);
`else
    return (i >= 0);
`endif
  endfunction

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    exp_if_rd = '0; exp_ls_rd = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle_outputs("reset");
    chk("reset_mem_addr",  mem_addr,  0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_if_rdata",  if_rdata,  0);
    chk("reset_ls_rdata",  ls_rdata,  0);

    xact("fetch", 1'b0, 1'b0, 8'h10, 16'h0000, 16'hA5A5, 1, 1'b0);
    xact("store", 1'b1, 1'b1, 8'h20, 16'h1234, 16'hFFFF, 0, 1'b0);
    xact("load",  1'b1, 1'b0, 8'h20, 16'h0000, 16'h1234, 2, 1'b0);

    // Reset held two cycles while a store is granted.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h33; ls_wdata = 16'hBEEF;
    tick();
    chk("midrst_pre_mem_we", mem_we, 1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ls_req = 1'b0;
    exp_if_rd = '0;
    exp_ls_rd = '0;
    chk_idle_outputs("midrst");
    chk("midrst_mem_addr",  mem_addr,  0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_if_rdata",  if_rdata,  0);
    chk("midrst_ls_rdata",  ls_rdata,  0);
    mem_rdata = 16'h7777;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_idle_outputs("midrst_late_ready");
    chk("midrst_late_ls_rdata", ls_rdata, 0);

    // Contention: both requesters held high for six grants.
    if_req = 1'b1; if_addr = 8'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h50;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("contend%0d_winner_addr", i), mem_addr, exp_ls_grant(i) ? 8'h50 : 8'h40);
      mem_rdata = 16'hC000 + 16'(i);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if (exp_ls_grant(i)) exp_ls_rd = 16'hC000 + 16'(i);
      else exp_if_rd = 16'hC000 + 16'(i);
      chk($sformatf("contend%0d_ls_valid", i), ls_valid, exp_ls_grant(i));
      chk($sformatf("contend%0d_if_valid", i), if_valid, !exp_ls_grant(i));
      chk($sformatf("contend%0d_ls_rdata", i), ls_rdata, exp_ls_rd);
      tick();
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    chk_idle_outputs("contend_end");

    // Spurious ready in IDLE and in RESP, then several memory delays.
    mem_rdata = 16'hDEAD;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_idle_outputs("spur_idle");
    xact("spur_resp", 1'b0, 1'b0, 8'h61, 16'h0000, 16'h5A5A, 0, 1'b1);
    xact("lat0", 1'b1, 1'b0, 8'h70, 16'h0000, 16'h0F0F, 0, 1'b0);
    xact("lat3", 1'b0, 1'b0, 8'h71, 16'h0000, 16'h3333, 3, 1'b0);
    xact("lat7", 1'b1, 1'b0, 8'h72, 16'h0000, 16'h7070, 7, 1'b0);
    xact("lat5", 1'b1, 1'b1, 8'h73, 16'hABCD, 16'h5555, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
